cpu6502_key_cond: RTL and testbench
===================================

Name: cpu6502_key_cond

Overview:
- Conditions the raw DE2 push-buttons before they reach the 6502 core; sits directly upstream of the CPU's reset and NMI inputs.
- Synchronises and debounces all four KEYs, then sequences the CPU reset (hold while pressed, plus a fixed stretch after release).
- Turns a KEY1 press into a bounded-width NMI assertion and exports clean press pulses for KEY3:2.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a new key level (1 ms at 50 MHz); minimum 2.
- RESET_HOLD, 8: cycles cpu_reset stays high after power-on/release before the CPU runs; minimum 1.
- NMI_WIDTH, 2: cycles nmi_out is held high per accepted KEY1 press; minimum 1.

Ports:
- CLK  in  1  system clock (CLOCK_50 domain).
- RESET  in  1  asynchronous, active-high block reset (power-on).
- KEY_N  in  4  raw DE2 keys, active-low (0 = pressed), asynchronous to CLK.
- cpu_reset  out  1  active-high reset to the 6502 core.
- nmi_out  out  1  active-high NMI request to the 6502 core.
- key_level  out  4  debounced key state, active-high (1 = pressed).
- key_press  out  4  one-cycle pulse on each debounced press edge.
- cpu_ce  out  1  CPU clock enable; see Optional Feature.

Behaviour:
- Async RESET values: cpu_reset=1, nmi_out=0, key_level=0, key_press=0, cpu_ce=0, FSM=HOLD, hold counter=0, NMI counter=0, debounce counters=0, sync flops=1 (released).
- Sync: two flops per KEY_N bit, then inversion to active-high.
- Debounce, per key:
  - If the synced value equals key_level[i], counter[i] clears.
  - Otherwise counter[i] increments; when it reaches DEBOUNCE_CYCLES-1, key_level[i] takes the synced value and counter[i] clears.
  - Any bounce back to the old level before that point clears counter[i].
  - Latency from a clean raw edge to key_level: 2 + DEBOUNCE_CYCLES cycles.
- key_press[i] is high for exactly one cycle, the cycle after key_level[i] goes 0->1. There is no pulse on release.
- Reset FSM (KEY0 = reset button):
  - HOLD: cpu_reset=1. Counter increments each cycle. At RESET_HOLD-1 go to RUN and clear the counter. If key_level[0]=1, go to PRESSED instead (takes priority).
  - RUN: cpu_reset=0. If key_level[0]=1, go to PRESSED.
  - PRESSED: cpu_reset=1, counter held at 0. When key_level[0]=0, go to HOLD.
  - cpu_reset is a registered output that follows the state with no extra lag: the first RUN cycle shows cpu_reset=0.
  - After power-on with no keys pressed, cpu_reset falls exactly RESET_HOLD cycles after RESET deasserts.
- NMI (KEY1):
  - key_press[1] while FSM=RUN and the NMI counter is 0: nmi_out=1 for exactly NMI_WIDTH cycles, starting the cycle after the pulse.
  - Presses while nmi_out=1 are ignored (no retrigger, no queueing).
  - Presses while the FSM is not RUN are discarded.
  - Entry to PRESSED or HOLD clears nmi_out and the NMI counter the same cycle. Reset wins over a simultaneous NMI.
- KEY3:2 have no internal effect beyond key_level and key_press.
- RESET asserted mid-operation: everything returns to reset values immediately, with no pulses emitted.
- Counter widths are $clog2 of their parameter, at least 1 bit. No counter wraps, because each clears at its terminal value.

Optional Feature:
- Macro: KEY_COND_STEP_EN.
- Defined: single-step mode.
  - cpu_ce=1 for one cycle after each key_press[3] while in RUN, otherwise 0.
  - cpu_ce=1 continuously while in HOLD or PRESSED, so reset vectors load.
  - key_press[3] is still exported.
- Undefined: cpu_ce is constant 1 after RESET deasserts (0 during RESET), and KEY3 has no internal effect.

Test Plan (DEBOUNCE_CYCLES=4, RESET_HOLD=8, NMI_WIDTH=2):
- Power-on: RESET high 3 cycles, KEY_N=4'hF, RESET low -> cpu_reset falls exactly 8 cycles later; nmi_out, key_level and key_press stay 0.
- Bounce: KEY_N[2] toggles 0/1 every 2 cycles for 20 cycles, then held 0 -> key_level[2] stays 0 during the toggling; after the hold it rises 6 cycles later; key_press[2]=1 for exactly 1 cycle.
- Reset button: in RUN, hold KEY_N[0]=0 for 30 cycles, then release -> cpu_reset rises 6 cycles after the press and stays high while held; after release it falls 6+8 cycles later.
- NMI: in RUN, press KEY1 -> nmi_out high for exactly 2 cycles, starting the cycle after key_press[1]. A second press landing while nmi_out=1 produces no extra cycle.
- NMI during reset: KEY1 press while cpu_reset=1 -> nmi_out stays 0. Async RESET pulsed while nmi_out=1 -> nmi_out and cpu_reset take reset values immediately, asynchronously.
- With KEY_COND_STEP_EN: in RUN, three KEY3 presses -> exactly three single-cycle cpu_ce pulses, and cpu_ce=0 otherwise. Without the macro, cpu_ce=1 throughout RUN.

Source files
------------

// File: rtl/cpu6502_key_cond.sv
// Push-button conditioner for the 6502 core: sync, debounce, CPU reset sequencing, NMI shaping.
// Optional single-step clock enable is built when KEY_COND_STEP_EN is defined.
module cpu6502_key_cond #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_HOLD      = 8,
  parameter int NMI_WIDTH       = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] KEY_N,
  output logic       cpu_reset,
  output logic       nmi_out,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic       cpu_ce
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int RH_W = ($clog2(RESET_HOLD) < 1) ? 1 : $clog2(RESET_HOLD);
  localparam int NM_W = ($clog2(NMI_WIDTH) < 1) ? 1 : $clog2(NMI_WIDTH);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RH_W-1:0] RH_LAST = RH_W'(RESET_HOLD - 1);
  localparam logic [NM_W-1:0] NM_LAST = NM_W'(NMI_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_PRESSED
  } state_t;

  logic [3:0]            r_sync1;
  logic [3:0]            r_sync2;
  logic [3:0]            w_synced;
  logic [3:0][DB_W-1:0]  r_db_cnt;
  logic [3:0][DB_W-1:0]  w_db_cnt_next;
  logic [3:0]            r_key_level;
  logic [3:0]            w_level_next;
  logic [3:0]            r_key_press;

  state_t                r_state;
  state_t                w_state_next;
  logic [RH_W-1:0]       r_hold_cnt;
  logic [RH_W-1:0]       w_hold_cnt_next;

  logic                  r_nmi;
  logic [NM_W-1:0]       r_nmi_cnt;
  logic                  w_nmi_trig;
  logic                  r_cpu_reset;
  logic                  r_cpu_ce;

  // Synchronisers idle at the released (high) level so nothing looks pressed out of reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      // NOTE: non-blocking assignments keep r_sync2 taking the old r_sync1, giving two real stages.
      r_sync1 <= KEY_N;
      r_sync2 <= r_sync1;
    end
  end

  assign w_synced = ~r_sync2;

  // A key level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_level_next  = r_key_level;
    w_db_cnt_next = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_synced[i] != r_key_level[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_level_next[i] = w_synced[i];
        end else begin
          w_db_cnt_next[i] = r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_db_cnt    <= '0;
      r_key_level <= '0;
      r_key_press <= '0;
    end else begin
      r_db_cnt    <= w_db_cnt_next;
      r_key_level <= w_level_next;
      r_key_press <= w_level_next & ~r_key_level;
    end
  end

  // The FSM reacts to the level being accepted this edge, so cpu_reset tracks key_level exactly.
  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = '0;
    case (r_state)
      ST_HOLD: begin
        if (w_level_next[0]) begin
          w_state_next = ST_PRESSED;
        end else if (r_hold_cnt == RH_LAST) begin
          w_state_next = ST_RUN;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (w_level_next[0]) w_state_next = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (!w_level_next[0]) w_state_next = ST_HOLD;
      end
      default: w_state_next = ST_HOLD;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_cpu_reset <= (w_state_next != ST_RUN);
    end
  end

  assign w_nmi_trig = (r_state == ST_RUN) && (w_state_next == ST_RUN) &&
                      r_key_press[1] && !r_nmi;

  // Leaving RUN kills any NMI in flight; a press during a pulse is dropped, not queued.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_nmi     <= 1'b0;
      r_nmi_cnt <= '0;
    end else if (w_state_next != ST_RUN) begin
      r_nmi     <= 1'b0;
      r_nmi_cnt <= '0;
    end else if (r_nmi) begin
      if (r_nmi_cnt == NM_LAST) begin
        r_nmi     <= 1'b0;
        r_nmi_cnt <= '0;
      end else begin
        r_nmi_cnt <= r_nmi_cnt + 1'b1;
      end
    end else if (w_nmi_trig) begin
      r_nmi     <= 1'b1;
      r_nmi_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cpu_ce <= 1'b0;
    end else begin
`ifdef KEY_COND_STEP_EN
      r_cpu_ce <= (w_state_next != ST_RUN) || ((r_state == ST_RUN) && r_key_press[3]);
`else
      r_cpu_ce <= 1'b1;
`endif
    end
  end

  assign cpu_reset = r_cpu_reset;
  assign nmi_out   = r_nmi;
  assign key_level = r_key_level;
  assign key_press = r_key_press;
  assign cpu_ce    = r_cpu_ce;

endmodule

// File: tb/tb_cpu6502_key_cond.sv
// Directed bench for cpu6502_key_cond (DEBOUNCE_CYCLES=4, RESET_HOLD=8, NMI_WIDTH=2).
// A second instance with a long NMI exercises the no-retrigger rule.
module tb_cpu6502_key_cond;

`ifdef KEY_COND_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] KEY_N;

  logic       cpu_reset, nmi_out, cpu_ce;
  logic [3:0] key_level, key_press;
  logic       w_cpu_reset, w_nmi_out, w_cpu_ce;
  logic [3:0] w_key_level, w_key_press;

  int n_vec = 0;
  int n_err = 0;

  cpu6502_key_cond #(.DEBOUNCE_CYCLES(4), .RESET_HOLD(8), .NMI_WIDTH(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .KEY_N(KEY_N),
    .cpu_reset(cpu_reset), .nmi_out(nmi_out), .key_level(key_level),
    .key_press(key_press), .cpu_ce(cpu_ce)
  );

  cpu6502_key_cond #(.DEBOUNCE_CYCLES(4), .RESET_HOLD(8), .NMI_WIDTH(16)) u_dut_wide (
    .CLK(CLK), .RESET(RESET), .KEY_N(KEY_N),
    .cpu_reset(w_cpu_reset), .nmi_out(w_nmi_out), .key_level(w_key_level),
    .key_press(w_key_press), .cpu_ce(w_cpu_ce)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1;
    KEY_N = 4'hF;
    tick(3);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_nmi", nmi_out, 0);
    check("rst_level", key_level, 0);
    check("rst_press", key_press, 0);
    check("rst_ce", cpu_ce, 0);

    // Power-on: cpu_reset falls exactly 8 cycles after RESET deasserts.
    RESET = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      check("pwr_cpu_reset", cpu_reset, (t < 8));
      check("pwr_ce", cpu_ce, (t < 8) ? 1'b1 : !STEP_EN);
      check("pwr_level", key_level, 0);
      check("pwr_press", key_press, 0);
      check("pwr_nmi", nmi_out, 0);
    end

    // Bounce on KEY2: 2-cycle runs never satisfy a 4-cycle debounce.
    for (int p = 0; p < 5; p++) begin
      KEY_N[2] = 1'b0;
      for (int t = 0; t < 2; t++) begin
        tick(1);
        check("bounce_level", key_level[2], 0);
      end
      KEY_N[2] = 1'b1;
      for (int t = 0; t < 2; t++) begin
        tick(1);
        check("bounce_level", key_level[2], 0);
      end
    end
    KEY_N[2] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick(1);
      check("k2_level", key_level[2], (t >= 6));
      check("k2_press", key_press[2], (t == 6));
      check("k2_cpu_reset", cpu_reset, 0);
    end
    KEY_N[2] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      check("k2_rel_press", key_press, 0);
      check("k2_rel_level", key_level[2], (t < 6));
    end

    // NMI: press at 0, release at 6, re-press at 12. Main NMI fires twice;
    // the wide NMI is still high at the second press and must not extend.
    KEY_N[1] = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      tick(1);
      if (t == 6)  KEY_N[1] = 1'b1;
      if (t == 12) KEY_N[1] = 1'b0;
      check("nmi_press", key_press[1], (t == 6) || (t == 18));
      check("nmi_out", nmi_out, (t == 7) || (t == 8) || (t == 19) || (t == 20));
      check("nmi_wide", w_nmi_out, (t >= 7) && (t <= 22));
    end
    KEY_N[1] = 1'b1;
    tick(8);
    check("nmi_rel_level", key_level, 0);

    // Reset button held 30 cycles; a KEY1 press during it must not raise NMI.
    KEY_N[0] = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick(1);
      if (t == 10) KEY_N[1] = 1'b0;
      check("rb_cpu_reset", cpu_reset, (t >= 6));
      check("rb_k1_press", key_press[1], (t == 16));
      check("rb_nmi", nmi_out, 0);
      check("rb_nmi_wide", w_nmi_out, 0);
    end
    KEY_N = 4'hF;
    for (int t = 1; t <= 14; t++) begin
      tick(1);
      check("rb_rel_cpu_reset", cpu_reset, (t < 14));
      check("rb_rel_nmi", nmi_out, 0);
    end
    check("rb_rel_level", key_level, 0);

    // Async RESET while nmi_out is high takes effect without a clock edge.
    KEY_N[1] = 1'b0;
    tick(7);
    check("ar_nmi_before", nmi_out, 1);
    #2;
    RESET = 1'b1;
    #1;
    check("ar_nmi", nmi_out, 0);
    check("ar_cpu_reset", cpu_reset, 1);
    check("ar_level", key_level, 0);
    check("ar_press", key_press, 0);
    check("ar_ce", cpu_ce, 0);
    KEY_N = 4'hF;
    tick(2);
    RESET = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      check("ar_pwr_cpu_reset", cpu_reset, (t < 8));
      check("ar_pwr_press", key_press, 0);
      check("ar_pwr_nmi", nmi_out, 0);
    end

    // KEY3 presses: single-cycle enables in step mode, constant 1 otherwise.
    for (int k = 0; k < 3; k++) begin
      KEY_N[3] = 1'b0;
      for (int t = 1; t <= 14; t++) begin
        tick(1);
        if (t == 6) KEY_N[3] = 1'b1;
        check("step_press", key_press[3], (t == 6));
        check("step_ce", cpu_ce, STEP_EN ? (t == 7) : 1'b1);
        check("step_cpu_reset", cpu_reset, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
